shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Two-master arbiter placed in front of a single-port synchronous memory (boot ROM or code RAM) shared by the Ibex instruction and data buses. It grants one request per cycle, gives data accesses priority, and bounds instruction starvation with a streak counter. It routes the one-cycle-latency memory response back to the requester that owns it, and answers out-of-range or illegal accesses with a bus error without touching the memory.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h0000_0000: byte base address of the memory window.
- `MEM_WORDS`, default 1024: memory depth in 32-bit words; power of two, ≥2.
- `WRITABLE`, default 1: 0 = memory is a ROM, so data writes return an error.
- `MAX_STREAK`, default 4: maximum consecutive data grants while an instruction request waits; range 1..15.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_req`  in  1;  `instr_addr`  in  32;  `instr_gnt`  out  1;  `instr_rvalid`  out  1;  `instr_rdata`  out  32;  `instr_err`  out  1.
- `data_req`  in  1;  `data_we`  in  1;  `data_be`  in  4;  `data_addr`  in  32;  `data_wdata`  in  32;  `data_gnt`  out  1;  `data_rvalid`  out  1;  `data_rdata`  out  32;  `data_err`  out  1.
- `mem_req`  out  1;  `mem_we`  out  1;  `mem_be`  out  4;  `mem_addr`  out  log2(MEM_WORDS)  word address;  `mem_wdata`  out  32.
- `mem_rdata`  in  32  valid the cycle after a read `mem_req`.

## Operation
- **Grant logic** is combinational and evaluated every cycle. At most one of `instr_gnt`/`data_gnt` is 1.
  - Only one master requesting: grant that master.
  - Both requesting: grant data, unless `streak == MAX_STREAK`; then grant instr.
- **Streak counter** (4-bit):
  - Data grant while `instr_req` = 1: streak +1, saturating at MAX_STREAK.
  - Any instr grant: streak = 0.
  - Cycle with no `instr_req`: streak = 0.
- **Address decode** on the granted request:
  - `offset = addr - ADDR_BASE`, 32-bit with wrap.
  - Legal when `offset < MEM_WORDS*4`.
  - The low 2 bits are ignored; `mem_addr = offset[2+:log2(MEM_WORDS)]`.
- **Legal access**: `mem_req` = 1 in the grant cycle.
  - `mem_we = data_we` for data grants; 0 for instr grants.
  - `mem_be` / `mem_wdata` pass through from the data bus; `mem_be` = 4'hF for instr grants.
- **Illegal access**: out-of-range address on either master, or `data_we` = 1 with WRITABLE = 0.
  - The grant is still given; `mem_req` = 0.
  - The response carries err = 1 and rdata = 0.
- **Response tag register** is written on every cycle: `{valid, owner, err}` from the current grant.
  - Next cycle, the owner's `rvalid` = 1, `err` = tag.err, `rdata` = `mem_rdata` if no error, else 0.
  - The non-owner's `rvalid` = 0 and its `rdata` = 0.
- **Writes** also produce `rvalid` (rdata = 0), matching Ibex protocol.
- **Idle**: `mem_req` = 0 and the `mem_*` outputs are driven to 0.

## Timing
- **Reset values** (all registered state): tag valid = 0, owner = instr, err = 0, streak = 0.
  - So after reset: `instr_rvalid`/`data_rvalid` = 0, both rdata = 0, both err = 0.
  - `instr_gnt`/`data_gnt`/`mem_*` follow the combinational rules; they are 0 while there are no requests.
- **Latency**: gnt in the same cycle as req (0 cycles); rvalid exactly 1 cycle after gnt; throughput one transaction per cycle.
- **Back-to-back grants to different masters**: each response goes to its own owner in consecutive cycles, with no bubble.
- A requester may drop `req` without a grant; no state changes as a result.
- **`rst` asserted mid-transaction**: the pending response is discarded (no rvalid after reset release). Streak clears immediately.
- **MAX_STREAK = 1**: strict alternation while both masters request continuously.

## Test plan
- **Reset**: hold rst with both req = 1, `mem_rdata` = 32'hDEAD_BEEF → both rvalid = 0, rdata = 0, err = 0. After release, the first cycle grants data.
- **Priority and starvation** (MAX_STREAK = 4): both req held 10 cycles, legal addresses → grant pattern D,D,D,D,I,D,D,D,D,I. Each rvalid goes to the matching owner one cycle later with `mem_rdata` routed.
- **Single master**: instr only, addr = ADDR_BASE + 8, `mem_rdata` = 32'h1234_5678 next cycle → `mem_addr` = 2, then `instr_rvalid` = 1, `instr_rdata` = 32'h1234_5678.
- **Out of range**: data read at ADDR_BASE + MEM_WORDS*4 → `data_gnt` = 1, `mem_req` = 0; next cycle `data_rvalid` = 1, `data_err` = 1, rdata = 0.
- **ROM write**: WRITABLE = 0, data write of 32'hA5A5_A5A5 to a legal address → `mem_req` = 0, `data_err` = 1 next cycle. With WRITABLE = 1 → `mem_we` = 1, `mem_be` = `data_be`, `mem_wdata` = 32'hA5A5_A5A5, err = 0.
- **Reset mid-operation**: assert rst the cycle after a grant → no rvalid is produced for that grant. After release, streak = 0: with both masters requesting, the first four grants go to data.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Two-master arbiter for a shared single-port synchronous memory on the Ibex buses.
// Data wins by default; a streak counter bounds how long an instruction request can wait.
module shared_mem_arbiter #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter bit          WRITABLE   = 1'b1,
    parameter int          MAX_STREAK = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req,
    input  logic [31:0]                  instr_addr,
    output logic                         instr_gnt,
    output logic                         instr_rvalid,
    output logic [31:0]                  instr_rdata,
    output logic                         instr_err,
    input  logic                         data_req,
    input  logic                         data_we,
    input  logic [3:0]                   data_be,
    input  logic [31:0]                  data_addr,
    input  logic [31:0]                  data_wdata,
    output logic                         data_gnt,
    output logic                         data_rvalid,
    output logic [31:0]                  data_rdata,
    output logic                         data_err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [3:0]                   mem_be,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int          AW           = $clog2(MEM_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  STREAK_MAX   = 4'(MAX_STREAK);
    localparam logic        OWNER_INSTR  = 1'b0;
    localparam logic        OWNER_DATA   = 1'b1;

    logic [3:0]  streak_r;
    logic [3:0]  streak_nxt_s;
    logic        grant_instr_s;
    logic        grant_data_s;
    logic        granted_s;
    logic [31:0] sel_addr_s;
    logic [31:0] offset_s;
    logic        illegal_s;
    logic [31:0] resp_data_s;
    logic        tag_valid_r;
    logic        tag_owner_r;
    logic        tag_err_r;
    logic        tag_we_r;

    // Grant selection: data first unless the waiting instruction fetch has hit the streak cap.
    always_comb begin
        grant_instr_s = 1'b0;
        grant_data_s  = 1'b0;
        if (data_req && !(instr_req && (streak_r == STREAK_MAX))) begin
            grant_data_s = 1'b1;
        end else if (instr_req) begin
            grant_instr_s = 1'b1;
        end else begin
            grant_instr_s = 1'b0;
        end
    end

    assign instr_gnt = grant_instr_s;
    assign data_gnt  = grant_data_s;
    assign granted_s = grant_instr_s | grant_data_s;

    // Streak update: counts data wins only while an instruction request is being held off.
    always_comb begin
        streak_nxt_s = streak_r;
        if (!instr_req || grant_instr_s) begin
            streak_nxt_s = 4'd0;
        end else if (grant_data_s && (streak_r < STREAK_MAX)) begin
            streak_nxt_s = streak_r + 4'd1;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Address decode of the granted request; the subtraction wraps so addresses below the base are illegal.
    always_comb begin
        sel_addr_s = grant_data_s ? data_addr : instr_addr;
        offset_s   = sel_addr_s - ADDR_BASE;
        illegal_s  = (offset_s >= WINDOW_BYTES) || (grant_data_s && data_we && !WRITABLE);
    end

    // Memory port drive; everything is zero unless a legal access is granted this cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        if (granted_s && !illegal_s) begin
            mem_req  = 1'b1;
            mem_addr = offset_s[2 +: AW];
            if (grant_data_s) begin
                mem_we    = data_we;
                mem_be    = data_be;
                mem_wdata = data_wdata;
            end else begin
                mem_we    = 1'b0;
                mem_be    = 4'hF;
                mem_wdata = 32'h0000_0000;
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    // Streak counter and response tag; reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r    <= 4'd0;
            tag_valid_r <= 1'b0;
            tag_owner_r <= OWNER_INSTR;
            tag_err_r   <= 1'b0;
            tag_we_r    <= 1'b0;
        end else begin
            streak_r    <= streak_nxt_s;
            tag_valid_r <= granted_s;
            tag_owner_r <= grant_data_s ? OWNER_DATA : OWNER_INSTR;
            tag_err_r   <= granted_s & illegal_s;
            tag_we_r    <= grant_data_s & data_we;
        end
    end

    // Write responses carry no data, so only clean reads forward the memory word.
    assign resp_data_s = (tag_err_r || tag_we_r) ? 32'h0000_0000 : mem_rdata;

    // Response routing to the owner recorded in the tag.
    always_comb begin
        instr_rvalid = 1'b0;
        instr_err    = 1'b0;
        instr_rdata  = 32'h0000_0000;
        data_rvalid  = 1'b0;
        data_err     = 1'b0;
        data_rdata   = 32'h0000_0000;
        if (tag_valid_r) begin
            case (tag_owner_r)
                OWNER_INSTR: begin
                    instr_rvalid = 1'b1;
                    instr_err    = tag_err_r;
                    instr_rdata  = resp_data_s;
                end
                OWNER_DATA: begin
                    data_rvalid = 1'b1;
                    data_err    = tag_err_r;
                    data_rdata  = resp_data_s;
                end
                default: begin
                    instr_rvalid = 1'b0;
                    data_rvalid  = 1'b0;
                end
            endcase
        end else begin
            instr_rvalid = 1'b0;
            data_rvalid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: directed stimulus pushes expected responses,
// negedge monitors pop and compare them for a writable instance and a ROM instance.
module tb_shared_mem_arbiter;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [1:0]  G_N  = 2'd0;
    localparam logic [1:0]  G_I  = 2'd1;
    localparam logic [1:0]  G_D  = 2'd2;

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, data_req, data_we;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] instr_rdata, data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, model_rdata;
    logic        ovr;

    logic        rom_en, rom_exp_err;
    logic        rom_data_req;
    logic        rom_instr_gnt, rom_instr_rvalid, rom_instr_err;
    logic        rom_data_gnt, rom_data_rvalid, rom_data_err;
    logic [31:0] rom_instr_rdata, rom_data_rdata;
    logic        rom_mem_req, rom_mem_we;
    logic [3:0]  rom_mem_be;
    logic [9:0]  rom_mem_addr;
    logic [31:0] rom_mem_wdata;

    exp_t q[$];
    exp_t rom_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.ADDR_BASE(BASE), .MEM_WORDS(1024), .WRITABLE(1'b1), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign rom_data_req = data_req & rom_en;

    shared_mem_arbiter #(.ADDR_BASE(BASE), .MEM_WORDS(1024), .WRITABLE(1'b0), .MAX_STREAK(4)) rom_dut (
        .clk(clk), .rst(rst),
        .instr_req(1'b0), .instr_addr(32'h0000_0000), .instr_gnt(rom_instr_gnt),
        .instr_rvalid(rom_instr_rvalid), .instr_rdata(rom_instr_rdata), .instr_err(rom_instr_err),
        .data_req(rom_data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(rom_data_gnt), .data_rvalid(rom_data_rvalid),
        .data_rdata(rom_data_rdata), .data_err(rom_data_err),
        .mem_req(rom_mem_req), .mem_we(rom_mem_we), .mem_be(rom_mem_be), .mem_addr(rom_mem_addr),
        .mem_wdata(rom_mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_val(input logic [9:0] w);
        return (w == 10'd2) ? 32'h1234_5678 : (32'h5A00_0000 | {22'd0, w});
    endfunction

    // Memory model: one-cycle read latency, junk after writes or idle cycles.
    always @(posedge clk) model_rdata <= (mem_req && !mem_we) ? mem_val(mem_addr) : 32'hDEAD_BEEF;
    assign mem_rdata = ovr ? 32'hDEAD_BEEF : model_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_resp(input string p, input logic have, input exp_t e,
                              input logic iv, input logic dv, input logic ie, input logic de,
                              input logic [31:0] ird, input logic [31:0] drd);
        if (!have) begin
            chk({p, "_idle_rvalid"}, {62'd0, iv, dv}, 64'd0);
            chk({p, "_idle_rdata"}, {ird, drd}, 64'd0);
        end else begin
            chk({p, "_instr_rvalid"}, 64'(iv), 64'(!e.owner));
            chk({p, "_data_rvalid"}, 64'(dv), 64'(e.owner));
            chk({p, "_err"}, 64'(e.owner ? de : ie), 64'(e.err));
            chk({p, "_rdata"}, 64'(e.owner ? drd : ird), 64'(e.rdata));
            chk({p, "_other_rdata"}, 64'(e.owner ? ird : drd), 64'd0);
        end
    endtask

    // Monitor for the writable instance.
    always @(negedge clk) begin : mon_main
        exp_t e;
        logic have;
        have = !rst && (q.size() > 0);
        e = have ? q.pop_front() : '0;
        check_resp("main", have, e, instr_rvalid, data_rvalid, instr_err, data_err, instr_rdata, data_rdata);
    end

    // Monitor for the ROM instance.
    always @(negedge clk) begin : mon_rom
        exp_t e;
        logic have;
        have = !rst && (rom_q.size() > 0);
        e = have ? rom_q.pop_front() : '0;
        check_resp("rom", have, e, rom_instr_rvalid, rom_data_rvalid, rom_instr_err, rom_data_err,
                   rom_instr_rdata, rom_data_rdata);
    end

    // One bus cycle: entered and left 1 time unit after a rising edge.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [1:0] eg, input logic ee, input logic [9:0] ema);
        exp_t e;
        instr_req = ir; instr_addr = ia; data_req = dr; data_we = dwe; data_addr = da;
        #2;
        chk("instr_gnt", 64'(instr_gnt), 64'(eg == G_I));
        chk("data_gnt", 64'(data_gnt), 64'(eg == G_D));
        chk("mem_req", 64'(mem_req), 64'((eg != G_N) && !ee));
        if ((eg != G_N) && !ee) begin
            chk("mem_addr", 64'(mem_addr), 64'(ema));
            chk("mem_we", 64'(mem_we), 64'((eg == G_D) && dwe));
            chk("mem_be", 64'(mem_be), 64'((eg == G_D) ? data_be : 4'hF));
            if ((eg == G_D) && dwe) chk("mem_wdata", 64'(mem_wdata), 64'(data_wdata));
        end else begin
            chk("mem_idle", {17'd0, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
        end
        if (rom_en) begin
            chk("rom_gnt", 64'(rom_data_gnt), 64'(dr));
            chk("rom_mem_req", 64'(rom_mem_req), 64'(!rom_exp_err));
        end
        @(posedge clk);
        #1;
        if (eg != G_N) begin
            e.owner = (eg == G_D);
            e.err   = ee;
            e.rdata = (ee || ((eg == G_D) && dwe)) ? 32'h0000_0000 : mem_val(ema);
            q.push_back(e);
        end
        if (rom_en) begin
            e.owner = 1'b1;
            e.err   = rom_exp_err;
            e.rdata = rom_exp_err ? 32'h0000_0000 : mem_val(ema);
            rom_q.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; ovr = 1'b1; rom_en = 1'b0; rom_exp_err = 1'b0;
        instr_req = 1'b1; instr_addr = BASE; data_req = 1'b1; data_we = 1'b0;
        data_addr = BASE + 32'd4; data_be = 4'hF; data_wdata = 32'h0000_0000;
        @(posedge clk);
        #1;
        // Reset held with both masters requesting and garbage on the memory bus.
        repeat (3) begin
            #2;
            chk("rst_rvalid", {62'd0, instr_rvalid, data_rvalid}, 64'd0);
            chk("rst_rdata", {instr_rdata, data_rdata}, 64'd0);
            chk("rst_err", {62'd0, instr_err, data_err}, 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; ovr = 1'b0;

        // Both masters saturating: D,D,D,D,I,D,D,D,D,I.
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                drive(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0, BASE + 32'(4 * (100 + i)), G_I, 1'b0, 10'(i));
            else
                drive(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0, BASE + 32'(4 * (100 + i)), G_D, 1'b0, 10'(100 + i));
        end

        // Single masters, back to back, window edges and out-of-range on both sides.
        drive(1'b1, BASE + 32'd8, 1'b0, 1'b0, BASE, G_I, 1'b0, 10'd2);
        drive(1'b0, BASE, 1'b1, 1'b0, BASE + 32'd4092, G_D, 1'b0, 10'd1023);
        drive(1'b1, BASE + 32'd4094, 1'b0, 1'b0, BASE, G_I, 1'b0, 10'd1023);
        drive(1'b0, BASE, 1'b1, 1'b0, BASE + 32'd4096, G_D, 1'b1, 10'd0);
        drive(1'b1, BASE - 32'd4, 1'b0, 1'b0, BASE, G_I, 1'b1, 10'd0);
        drive(1'b0, BASE, 1'b0, 1'b0, BASE, G_N, 1'b0, 10'd0);

        // Writes: legal on the RAM instance, a bus error on the ROM instance.
        rom_en = 1'b1; rom_exp_err = 1'b1; data_be = 4'h3; data_wdata = 32'hA5A5_A5A5;
        drive(1'b0, BASE, 1'b1, 1'b1, BASE + 32'd16, G_D, 1'b0, 10'd4);
        rom_exp_err = 1'b0; data_be = 4'hF;
        drive(1'b0, BASE, 1'b1, 1'b0, BASE + 32'd12, G_D, 1'b0, 10'd3);
        rom_en = 1'b0;
        drive(1'b0, BASE, 1'b0, 1'b0, BASE, G_N, 1'b0, 10'd0);

        // Build a streak of 3, then reset the cycle after a grant.
        for (int i = 0; i < 3; i++)
            drive(1'b1, BASE + 32'd40, 1'b1, 1'b0, BASE + 32'(4 * (20 + i)), G_D, 1'b0, 10'(20 + i));
        rst = 1'b1;
        q.delete();
        #2;
        chk("midrst_rvalid", {62'd0, instr_rvalid, data_rvalid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4)
                drive(1'b1, BASE + 32'd40, 1'b1, 1'b0, BASE + 32'(4 * (30 + i)), G_I, 1'b0, 10'd10);
            else
                drive(1'b1, BASE + 32'd40, 1'b1, 1'b0, BASE + 32'(4 * (30 + i)), G_D, 1'b0, 10'(30 + i));
        end
        drive(1'b0, BASE, 1'b0, 1'b0, BASE, G_N, 1'b0, 10'd0);
        drive(1'b0, BASE, 1'b0, 1'b0, BASE, G_N, 1'b0, 10'd0);
        chk("queue_drained", 64'(q.size() + rom_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
